// File: rtl/my_pe_pkg.sv
// Shared definitions for the my_pe processing element and its sequencer.
package my_pe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_PRIME,
    ST_FIRE,
    ST_WAIT,
    ST_DONE
  } pe_ctrl_state_t;

  localparam int unsigned PE_CLEAR_CYCLES = 2;
  localparam int unsigned PE_CLR_CNT_W    = 2;

endpackage

// File: rtl/my_pe_ctrl.sv
// Sequencer for one my_pe: clears the accumulator, optionally loads weights,
// then issues activations one at a time, waiting for each accumulated result.
module my_pe_ctrl
  import my_pe_pkg::*;
#(
  parameter int unsigned VECTOR_SIZE = 32,
  parameter int unsigned L_RAM_SIZE  = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic                    reload,
  input  logic [L_RAM_SIZE:0]     len,
  input  logic [VECTOR_SIZE-1:0]  w_tdata,
  input  logic                    w_tvalid,
  output logic                    w_tready,
  input  logic [VECTOR_SIZE-1:0]  a_tdata,
  input  logic                    a_tvalid,
  output logic                    a_tready,
  output logic                    busy,
  output logic                    done,
  output logic [VECTOR_SIZE-1:0]  result,
  output logic                    pe_aresetn,
  output logic [VECTOR_SIZE-1:0]  pe_ain,
  output logic [VECTOR_SIZE-1:0]  pe_din,
  output logic [L_RAM_SIZE-1:0]   pe_addr,
  output logic                    pe_we,
  output logic                    pe_valid,
  input  logic                    pe_dvalid,
  input  logic [VECTOR_SIZE-1:0]  pe_dout
);

  localparam int unsigned CNT_W = L_RAM_SIZE + 1;
  localparam int unsigned DEPTH = 2 ** L_RAM_SIZE;

  pe_ctrl_state_t          r_state;
  pe_ctrl_state_t          w_next;
  logic [CNT_W-1:0]        r_n;
  logic [CNT_W-1:0]        r_wcnt;
  logic [CNT_W-1:0]        r_ecnt;
  logic [PE_CLR_CNT_W-1:0] r_clr_cnt;
  logic                    r_reload;
  logic                    r_w_tready;
  logic                    r_a_tready;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_pe_aresetn;
  logic [L_RAM_SIZE-1:0]   r_addr;
  logic [VECTOR_SIZE-1:0]  r_result;

  logic [CNT_W-1:0]        w_len_clamped;
  logic                    w_w_hs;
  logic                    w_a_hs;
  logic                    w_w_last;
  logic                    w_e_last;
  logic                    w_clr_end;

  assign w_len_clamped = (len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : len;
  assign w_w_hs        = (r_state == ST_LOAD) && w_tvalid;
  assign w_a_hs        = (r_state == ST_FIRE) && a_tvalid;
  assign w_w_last      = (r_wcnt == (r_n - 1'b1));
  assign w_e_last      = ((r_ecnt + 1'b1) == r_n);
  assign w_clr_end     = (r_clr_cnt == PE_CLR_CNT_W'(PE_CLEAR_CYCLES - 1));

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = (w_len_clamped == '0) ? ST_DONE : ST_CLEAR;
      ST_CLEAR: if (w_clr_end) w_next = r_reload ? ST_LOAD : ST_PRIME;
      ST_LOAD:  if (w_w_hs && w_w_last) w_next = ST_PRIME;
      ST_PRIME: w_next = ST_FIRE;
      ST_FIRE:  if (w_a_hs) w_next = ST_WAIT;
      ST_WAIT:  if (pe_dvalid) w_next = w_e_last ? ST_DONE : ST_FIRE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state      <= ST_IDLE;
      r_n          <= '0;
      r_wcnt       <= '0;
      r_ecnt       <= '0;
      r_clr_cnt    <= '0;
      r_reload     <= 1'b0;
      r_w_tready   <= 1'b0;
      r_a_tready   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pe_aresetn <= 1'b0;
      r_addr       <= '0;
      r_result     <= '0;
    end else begin
      r_state      <= w_next;
      r_busy       <= (w_next != ST_IDLE);
      r_done       <= (w_next == ST_DONE);
      r_w_tready   <= (w_next == ST_LOAD);
      r_a_tready   <= (w_next == ST_FIRE);
      r_pe_aresetn <= (w_next != ST_CLEAR);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_n       <= w_len_clamped;
            r_reload  <= reload;
            r_clr_cnt <= '0;
            r_wcnt    <= '0;
            r_ecnt    <= '0;
            r_addr    <= '0;
            if (w_len_clamped == '0) r_result <= '0;
          end
        end
        ST_CLEAR: r_clr_cnt <= r_clr_cnt + 1'b1;
        ST_LOAD: begin
          if (w_w_hs) begin
            r_wcnt <= r_wcnt + 1'b1;
            // Rewind to address 0 so PRIME reads the first weight
            r_addr <= w_w_last ? '0 : L_RAM_SIZE'(r_addr + 1'b1);
          end
        end
        ST_FIRE: if (w_a_hs) r_addr <= L_RAM_SIZE'(r_ecnt + 1'b1);
        ST_WAIT: begin
          if (pe_dvalid) begin
            r_ecnt <= r_ecnt + 1'b1;
            if (w_e_last) r_result <= pe_dout;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_tready   = r_w_tready;
  assign a_tready   = r_a_tready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign pe_aresetn = r_pe_aresetn;
  assign pe_addr    = r_addr;

  // Write data passes straight through so it lines up with the same-cycle pe_we
  assign pe_din   = w_tdata;
  assign pe_we    = w_w_hs;
  assign pe_ain   = a_tdata;
  assign pe_valid = w_a_hs;

endmodule
